fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 16-bit pipelined core. Owns the PC, drives the instruction-memory address, and latches the fetched instruction together with PC+2 into the IF/ID register. The decode stage's control decoder consumes that register. Handles stall, redirect (branch/jump flush from later stages), speculative HALT detection and misaligned-PC error.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_INSTR, 16'h0800, bubble encoding (opcode 5'b00001) inserted on flush/halt/error

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  from hazard unit; hold PC and IF/ID
- redirect  input  1  taken branch/jump resolved downstream; flush and load redirect_pc
- redirect_pc  input  16  target PC for redirect
- imem_addr  output  16  instruction-memory address (= PC register)
- imem_data  input  16  instruction word, combinationally valid in same cycle as imem_addr
- if_id_instr  output  16  registered instruction to decode
- if_id_pc2  output  16  registered PC+2 of that instruction
- if_id_valid  output  1  1 = if_id_instr is a real fetched instruction
- halted  output  1  HALT (opcode 5'b00000) fetched and not yet squashed; fetch frozen
- err  output  1  sticky misaligned-fetch error

## Operation
- Registers: pc[15:0], if_id_instr, if_id_pc2, if_id_valid, halt_pend, err_r. halted = halt_pend, err = err_r, imem_addr = pc.
- pc_plus2 = pc + 2, modulo 2^16 (0xFFFE wraps to 0x0000, no error).
- Per-edge priority, highest first:
  1. rst: pc<=RESET_PC; if_id_instr<=NOP_INSTR; if_id_pc2<=0; if_id_valid<=0; halt_pend<=0; err_r<=0.
  2. redirect (overrides stall, halt, err): pc<=redirect_pc; if_id_instr<=NOP_INSTR; if_id_valid<=0; halt_pend<=0 (HALT was on wrong path). err_r unchanged.
  3. err_r or halt_pend: pc holds; IF/ID loads NOP_INSTR with valid 0.
  4. stall: pc, IF/ID, halt_pend all hold.
  5. pc[0]==1: err_r<=1; IF/ID loads NOP, valid 0; pc holds.
  6. Normal: if_id_instr<=imem_data; if_id_pc2<=pc_plus2; if_id_valid<=1; pc<=pc_plus2; if imem_data[15:11]==5'b00000, halt_pend<=1 (the HALT itself is latched valid so decode asserts dump).
- States (implicit in halt_pend/err_r): RUN, HALT_WAIT (halt_pend), ERROR (err_r, exit only via rst). HALT_WAIT -> RUN only on redirect.
- Redirect to odd address: accepted; error raised on the following cycle's fetch.

## Timing
- Fetch latency 1 cycle: instruction at pc appears on if_id_instr after the next rising edge.
- After rst deasserts, first valid if_id_valid at edge 1 with if_id_instr = imem_data at RESET_PC.
- Redirect penalty: edge with redirect=1 produces one bubble; target instruction valid at the following edge.
- stall=1 for N cycles: outputs bit-identical for N cycles; fetch resumes at the edge after stall drops.
- stall and redirect same cycle: redirect wins.
- HALT fetch and redirect same cycle: redirect wins; halt_pend stays 0.
- err rises at the edge after the misaligned PC is presented; stays 1 until rst.
- rst mid-stream: all outputs return to reset values on that edge regardless of other inputs.

## Test plan
- Reset then sequential fetch from 0x0000 with memory words 0x4001,0x4102,0x4203 -> if_id_instr follows that sequence on edges 1-3, if_id_pc2 = 0x0002,0x0004,0x0006, valid=1.
- Stall held 3 cycles at pc=0x0004 -> imem_addr, if_id_* unchanged for 3 cycles; next edge fetches 0x0004's word.
- Redirect to 0x0100 asserted together with stall -> next edge: if_id_instr=0x0800, valid=0, imem_addr=0x0100; following edge valid instruction from 0x0100, pc2=0x0102.
- HALT (0x0000) at 0x0008 -> if_id_instr=0x0000 valid=1, halted=1, imem_addr frozen at 0x000A, bubbles after; redirect to 0x0020 clears halted and resumes.
- Redirect to 0x0031 -> next cycle err=1, bubbles, pc frozen; redirect doesn't clear err; rst clears to 0.
- PC at 0xFFFE with normal fetch -> if_id_pc2=0x0000, imem_addr=0x0000, err=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 16-bit core.
// Handles stall, downstream redirect, speculative HALT freeze and misaligned-PC error.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc2,
    output logic        if_id_valid,
    output logic        halted,
    output logic        err
);

    // HALT_WAIT and ERROR are mutually exclusive: each is only entered from RUN.
    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT_WAIT,
        ST_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc2_q, pc2_d;
    logic        valid_q, valid_d;
    logic [15:0] pc_plus2;

    assign pc_plus2 = pc_q + 16'd2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc2_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc2_q   <= pc2_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc2_d   = pc2_q;
        valid_d = valid_q;

        if (redirect) begin
            pc_d    = redirect_pc;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            if (state_q == ST_HALT_WAIT) begin
                state_d = ST_RUN;
            end
        end else if (state_q != ST_RUN) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pc_q[0]) begin
            state_d = ST_ERROR;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else begin
            instr_d = imem_data;
            pc2_d   = pc_plus2;
            valid_d = 1'b1;
            pc_d    = pc_plus2;
            if (imem_data[15:11] == 5'b00000) begin
                state_d = ST_HALT_WAIT;
            end
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc2   = pc2_q;
    assign if_id_valid = valid_q;
    assign halted      = (state_q == ST_HALT_WAIT);
    assign err         = (state_q == ST_ERROR);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random traffic
// compared each cycle against a flag-based model of the fetch rules.
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc2;
    logic        if_id_valid;
    logic        halted;
    logic        err;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [0:65535];

    // reference model state
    logic [15:0] m_pc, m_instr, m_pc2;
    logic        m_valid, m_halt, m_err;

    logic [50:0] obs;

    fetch_stage #(
        .RESET_PC (16'h0000),
        .NOP_INSTR(16'h0800)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .if_id_instr(if_id_instr),
        .if_id_pc2  (if_id_pc2),
        .if_id_valid(if_id_valid),
        .halted     (halted),
        .err        (err)
    );

    assign imem_data = mem[imem_addr];
    assign obs = {imem_addr, if_id_instr, if_id_pc2, if_id_valid, halted, err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [50:0] exp_vec();
        return {m_pc, m_instr, m_pc2, m_valid, m_halt, m_err};
    endfunction

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:11] == 5'b00000) w[11] = 1'b1;
        return w;
    endfunction

    // Applies the fetch rules in priority order for one clock edge.
    task automatic model_step(input logic r, input logic s, input logic rd, input logic [15:0] rp);
        logic [15:0] word;
        if (r) begin
            m_pc = 16'h0000; m_instr = NOP; m_pc2 = 16'h0000;
            m_valid = 1'b0; m_halt = 1'b0; m_err = 1'b0;
        end else if (rd) begin
            m_pc = rp; m_instr = NOP; m_valid = 1'b0; m_halt = 1'b0;
        end else if (m_err || m_halt) begin
            m_instr = NOP; m_valid = 1'b0;
        end else if (s) begin
            m_valid = m_valid;
        end else if (m_pc[0]) begin
            m_err = 1'b1; m_instr = NOP; m_valid = 1'b0;
        end else begin
            word    = mem[m_pc];
            m_instr = word;
            m_pc2   = m_pc + 16'd2;
            m_valid = 1'b1;
            m_pc    = m_pc + 16'd2;
            if (word[15:11] == 5'b00000) m_halt = 1'b1;
        end
    endtask

    task automatic tick(input logic r, input logic s, input logic rd, input logic [15:0] rp);
        rst = r; stall = s; redirect = rd; redirect_pc = rp;
        model_step(r, s, rd, rp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h1234;
        tick(1'b1, 1'b1, 1'b1, 16'h1234);
        checks++;
        if (obs !== {16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset got=%h exp=%h", obs, {16'h0000, 16'h0800, 16'h0000, 3'b000});
        end
    endtask

    task automatic test_sequential();
        logic [15:0] words [3];
        words = '{16'h4001, 16'h4102, 16'h4203};
        for (int i = 0; i < 3; i++) mem[2*i] = words[i];
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 16'h0000);
            checks++;
            if ({if_id_instr, if_id_pc2, if_id_valid} !== {words[i], 16'(2*i+2), 1'b1}) begin
                errors++;
                $display("FAIL seq[%0d] got=%h/%h/%b exp=%h/%h/1", i, if_id_instr, if_id_pc2,
                         if_id_valid, words[i], 16'(2*i+2));
            end
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL seq_model[%0d] got=%h exp=%h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_stall();
        tick(1'b1, 1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b0, 16'h0000);
            checks++;
            if ({imem_addr, if_id_instr, if_id_pc2, if_id_valid} !== {16'h0004, 16'h4102, 16'h0004, 1'b1}) begin
                errors++;
                $display("FAIL stall[%0d] got=%h/%h/%h/%b exp=0004/4102/0004/1", i, imem_addr,
                         if_id_instr, if_id_pc2, if_id_valid);
            end
        end
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if ({imem_addr, if_id_instr, if_id_pc2} !== {16'h0006, 16'h4203, 16'h0006}) begin
            errors++;
            $display("FAIL stall_resume got=%h/%h/%h exp=0006/4203/0006", imem_addr, if_id_instr, if_id_pc2);
        end
    endtask

    task automatic test_redirect_stall();
        mem[16'h0100] = 16'h5A5A;
        tick(1'b0, 1'b1, 1'b1, 16'h0100);
        checks++;
        if ({if_id_instr, if_id_valid, imem_addr} !== {16'h0800, 1'b0, 16'h0100}) begin
            errors++;
            $display("FAIL redir_bubble got=%h/%b/%h exp=0800/0/0100", if_id_instr, if_id_valid, imem_addr);
        end
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if ({if_id_instr, if_id_pc2, if_id_valid} !== {16'h5A5A, 16'h0102, 1'b1}) begin
            errors++;
            $display("FAIL redir_target got=%h/%h/%b exp=5a5a/0102/1", if_id_instr, if_id_pc2, if_id_valid);
        end
    endtask

    task automatic test_halt();
        mem[16'h0008] = 16'h0000;
        mem[16'h0020] = 16'h6020;
        mem[16'h0022] = 16'h0000;
        mem[16'h0040] = 16'h7040;
        tick(1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if ({if_id_instr, if_id_valid, halted, imem_addr} !== {16'h0000, 1'b1, 1'b1, 16'h000A}) begin
            errors++;
            $display("FAIL halt_fetch got=%h/%b/%b/%h exp=0000/1/1/000a", if_id_instr, if_id_valid, halted, imem_addr);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0, 1'b0, 16'h0000);
            checks++;
            if ({if_id_instr, if_id_valid, halted, imem_addr} !== {16'h0800, 1'b0, 1'b1, 16'h000A}) begin
                errors++;
                $display("FAIL halt_bubble[%0d] got=%h/%b/%b/%h exp=0800/0/1/000a", i, if_id_instr,
                         if_id_valid, halted, imem_addr);
            end
        end
        tick(1'b0, 1'b0, 1'b1, 16'h0020);
        checks++;
        if ({halted, imem_addr, if_id_valid} !== {1'b0, 16'h0020, 1'b0}) begin
            errors++;
            $display("FAIL halt_clear got=%b/%h/%b exp=0/0020/0", halted, imem_addr, if_id_valid);
        end
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if ({if_id_instr, if_id_valid} !== {16'h6020, 1'b1}) begin
            errors++;
            $display("FAIL halt_resume got=%h/%b exp=6020/1", if_id_instr, if_id_valid);
        end
        // HALT word sits at pc while a redirect arrives: redirect must win
        tick(1'b0, 1'b0, 1'b1, 16'h0040);
        checks++;
        if ({halted, if_id_valid, imem_addr} !== {1'b0, 1'b0, 16'h0040}) begin
            errors++;
            $display("FAIL halt_vs_redir got=%b/%b/%h exp=0/0/0040", halted, if_id_valid, imem_addr);
        end
    endtask

    task automatic test_misaligned();
        tick(1'b0, 1'b0, 1'b1, 16'h0031);
        checks++;
        if ({err, imem_addr} !== {1'b0, 16'h0031}) begin
            errors++;
            $display("FAIL mis_accept got=%b/%h exp=0/0031", err, imem_addr);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0, 1'b0, 16'h0000);
            checks++;
            if ({err, if_id_instr, if_id_valid, imem_addr} !== {1'b1, 16'h0800, 1'b0, 16'h0031}) begin
                errors++;
                $display("FAIL mis_err[%0d] got=%b/%h/%b/%h exp=1/0800/0/0031", i, err, if_id_instr,
                         if_id_valid, imem_addr);
            end
        end
        tick(1'b0, 1'b0, 1'b1, 16'h0040);
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if ({err, if_id_valid, imem_addr} !== {1'b1, 1'b0, 16'h0040}) begin
            errors++;
            $display("FAIL mis_sticky got=%b/%b/%h exp=1/0/0040", err, if_id_valid, imem_addr);
        end
        tick(1'b1, 1'b0, 1'b0, 16'h0000);
        checks++;
        if (obs !== exp_vec() || err !== 1'b0) begin
            errors++;
            $display("FAIL mis_reset got=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_wrap();
        mem[16'hFFFE] = 16'h3FFE;
        tick(1'b0, 1'b0, 1'b1, 16'hFFFE);
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if ({if_id_instr, if_id_pc2, imem_addr, err, if_id_valid} !== {16'h3FFE, 16'h0000, 16'h0000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL wrap got=%h/%h/%h/%b/%b exp=3ffe/0000/0000/0/1", if_id_instr, if_id_pc2,
                     imem_addr, err, if_id_valid);
        end
    endtask

    task automatic test_random();
        logic        r, s, rd;
        logic [15:0] rp;
        for (int i = 0; i < 64; i++) mem[16'($urandom_range(0, 511)) & 16'hFFFE] = 16'($urandom_range(0, 2047));
        tick(1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 20);
            rd = ($urandom_range(0, 99) < 10);
            rp = 16'($urandom_range(0, 511)) & (($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'hFFFE);
            tick(r, s, rd, rp);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d] got=%h exp=%h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = rand_word();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_halt();
        test_misaligned();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
